// File: rtl/hex_display_arbiter.sv
// Arbitrates the six seven-segment displays between switch nibbles, HPS segment
// words and a latched datapath status word, with a debounced mode key and status override.
module hex_display_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 100000000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        key_mode,
  input  logic [23:0] sw_value,
  input  logic [31:0] hps_hex3_hex0,
  input  logic [15:0] hps_hex5_hex4,
  input  logic        status_valid,
  input  logic [23:0] status_value,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [1:0]  mode,
  output logic        override_active
);

  typedef enum logic [1:0] {
    ST_SW       = 2'd0,
    ST_HPS      = 2'd1,
    ST_STATUS   = 2'd2,
    ST_OVERRIDE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;
  logic             key_deb_q, key_deb_d;
  logic             key_deb_prev_q, key_deb_prev_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  state_t           state_q, state_d;
  state_t           saved_q, saved_d;
  logic [23:0]      status_q, status_d;
  logic [5:0][6:0]  hex_q, hex_d;
  logic             advance;
  logic [47:0]      hps_all;
  logic             unused_hps_msb;

  function automatic logic [6:0] hexdec(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  function automatic state_t next_mode(input state_t s);
    state_t n;
    case (s)
      ST_SW:   n = ST_HPS;
      ST_HPS:  n = ST_STATUS;
      default: n = ST_SW;
    endcase
    return n;
  endfunction

  assign hps_all        = {hps_hex5_hex4, hps_hex3_hex0};
  assign unused_hps_msb = ^{hps_all[47], hps_all[39], hps_all[31],
                            hps_all[23], hps_all[15], hps_all[7]};

  always_comb begin
    key_meta_d     = key_mode;
    key_sync_d     = key_meta_q;
    key_deb_d      = key_deb_q;
    key_deb_prev_d = key_deb_q;
    deb_cnt_d      = '0;
    if (key_sync_q != key_deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        key_deb_d = key_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign advance = key_deb_q & ~key_deb_prev_q;

  // A strobe always wins over a same-cycle advance; the saved mode is only
  // captured on entry so retriggers keep the original mode to return to.
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    hold_cnt_d = hold_cnt_q;
    status_d   = status_q;
    if (status_valid) begin
      status_d   = status_value;
      hold_cnt_d = HOLD_LOAD;
      state_d    = ST_OVERRIDE;
      if (state_q != ST_OVERRIDE) begin
        saved_d = state_q;
      end
    end else if (state_q == ST_OVERRIDE) begin
      if (advance) begin
        state_d    = next_mode(saved_q);
        hold_cnt_d = '0;
      end else if (hold_cnt_q <= CNT_W'(1)) begin
        state_d    = saved_q;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q - 1'b1;
      end
    end else if (advance) begin
      state_d = next_mode(state_q);
    end
  end

  always_comb begin
    hex_d = '1;
    for (int unsigned n = 0; n < 6; n++) begin
      case (state_q)
        ST_SW:   hex_d[n] = hexdec(sw_value[4*n +: 4]);
        ST_HPS:  hex_d[n] = ~hps_all[8*n +: 7];
        default: hex_d[n] = hexdec(status_q[4*n +: 4]);
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_meta_q     <= 1'b0;
      key_sync_q     <= 1'b0;
      key_deb_q      <= 1'b0;
      key_deb_prev_q <= 1'b0;
      deb_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      state_q        <= ST_SW;
      saved_q        <= ST_SW;
      status_q       <= '0;
      hex_q          <= '1;
    end else begin
      key_meta_q     <= key_meta_d;
      key_sync_q     <= key_sync_d;
      key_deb_q      <= key_deb_d;
      key_deb_prev_q <= key_deb_prev_d;
      deb_cnt_q      <= deb_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      state_q        <= state_d;
      saved_q        <= saved_d;
      status_q       <= status_d;
      hex_q          <= hex_d;
    end
  end

  assign mode            = (state_q == ST_OVERRIDE) ? 2'd2 : state_q;
  assign override_active = (state_q == ST_OVERRIDE);

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares the six on-board seven-segment displays (HEX0..HEX5) among three sources:
  - slider-switch nibbles, decoded to hex digits;
  - raw segment words from the HPS PIO registers (hex3_hex0 / hex5_hex4);
  - a latched status/result word from the matrix-multiply datapath, decoded to hex digits.
- A debounced pushbutton cycles the display mode.
- A status strobe pre-empts the current mode for a fixed hold time, then restores it.
- Sits in the board top level, between Computer_System / switch inputs and the HEX pins.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised key must stay stable before a level change is accepted (20 ms at 50 MHz).
- HOLD_CYCLES, 100000000, cycles the status override stays on the displays after its last strobe (2 s at 50 MHz).
- CNT_W, 27, width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- key_mode  in  1  raw pushbutton, active-high (already inverted from KEY), asynchronous, bouncy
- sw_value  in  24  six hex nibbles; [3:0] goes to HEX0 … [23:20] goes to HEX5
- hps_hex3_hex0  in  32  HPS segment word, active-high segments, byte n bits [6:0] → HEXn
- hps_hex5_hex4  in  16  HPS segment word for HEX4/HEX5, same byte layout
- status_valid  in  1  single-cycle strobe; captures status_value
- status_value  in  24  six hex nibbles from the datapath
- HEX0..HEX5  out  7 each  segment drives, active-low, bit 6 = g … bit 0 = a
- mode  out  2  0 = SW, 1 = HPS, 2 = STATUS; 3 never occurs
- override_active  out  1  high while the status override owns the displays

Behaviour:
- One clock domain, CLOCK_50. Reset is synchronous, active-high.
- State on reset:
  - HEX0..HEX5 = 7'h7F (blank); mode = 0; override_active = 0.
  - Saved mode = 0; status latch = 0; all counters = 0; key synchroniser and debounced key = 0.
- Key path:
  - 2-FF synchroniser feeds a debounce counter.
  - The counter increments while the synchronised value differs from debounced key, and clears when they match.
  - On reaching DEBOUNCE_CYCLES the debounced key takes the synchronised value.
  - A rising edge of the debounced key produces a one-cycle advance event.
  - Total latency from a clean key rise to the mode change is DEBOUNCE_CYCLES+3 cycles, ±1.
- Mode FSM states: SW, HPS, STATUS, OVERRIDE.
  - Advance event in SW, HPS or STATUS: step to the next state (SW→HPS→STATUS→SW, wraps).
  - status_valid in any state: latch status_value, load the hold counter with HOLD_CYCLES, enter OVERRIDE. The saved mode records the prior state; it is not overwritten if already in OVERRIDE.
  - status_valid while in OVERRIDE: relatch the value and reload the counter (retrigger).
  - Hold counter reaches 1 with no new strobe: return to the saved mode on the next edge. OVERRIDE lasts exactly HOLD_CYCLES cycles.
  - Advance event during OVERRIDE: override ends at once; next state = saved mode + 1 (wraps).
  - status_valid and advance event in the same cycle: status wins and the advance event is dropped.
- Output mode values: mode = 2 and override_active = 1 in OVERRIDE; otherwise mode = the current state and override_active = 0.
- Display sources:
  - SW mode: HEXn = hexdec(sw_value[4n+3:4n]).
  - HPS mode: HEXn = ~(HPS byte n bits [6:0]); bit 7 of each byte is ignored.
  - STATUS and OVERRIDE: HEXn = hexdec(latched status nibble n).
- hexdec (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- HEX outputs are registered: one cycle of latency from a source-data or state change to the pins.
- Source inputs are sampled live every cycle; only status_value is latched.

Test Plan:
- Reset and SW path: hold reset 3 cycles → all HEX = 7F, mode = 0. Release with sw_value = 24'h012345 → one cycle later HEX0 = 0010010, HEX1 = 0011001, HEX5 = 1000000.
- Debounce (DEBOUNCE_CYCLES = 4): a 2-cycle key glitch → mode stays 0. Then key held 12 cycles → mode = 1 exactly once. With hps_hex3_hex0 = 32'h063F5B4F → HEX0 = ~4F = 0110000, HEX3 = ~06 = 1111001.
- Override (HOLD_CYCLES = 8) from mode 1: status_valid with value 24'hABCDEF → override_active high for exactly 8 cycles, HEX0 = 0001110 (F), HEX5 = 0001000 (A); then mode returns to 1 and HPS patterns reappear.
- Retrigger: second strobe 5 cycles into an override with value 24'h000008 → hold restarts (13 cycles of override total), HEX0 = 0000000.
- Key edge coincident with status_valid → override starts, advance dropped; after the hold, mode = the prior mode. A key advance during an override from mode 2 → override ends, mode = 0.
- Reset asserted mid-override → next cycle all HEX = 7F, mode = 0, override_active = 0, status latch cleared (STATUS mode then shows 1000000 on every digit).
